// File: rtl/thrd_cmd_arbiter.sv
// Round-robin arbiter serialising per-CPU RUN/STOP requests onto the threads manager command port.
// Define THRD_ARB_QUANTUM_EN to add the periodic GET_NEXT_STATE tick (quantum counter, pending flag, TICK state).
module thrd_cmd_arbiter #(
  parameter int CPU_QUANTITY = 4,
  parameter int QUANTUM      = 64,
  parameter int DATA_SIZE    = 32,
  parameter int ADDR_SIZE    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CPU_QUANTITY-1:0]           req,
  input  logic [4*CPU_QUANTITY-1:0]         cmd_in,
  input  logic [DATA_SIZE*CPU_QUANTITY-1:0] data_in,
  input  logic [ADDR_SIZE*CPU_QUANTITY-1:0] addr_in,
  output logic [CPU_QUANTITY-1:0]           done,
  output logic [1:0]                        rslt,
  output logic [DATA_SIZE-1:0]              rslt_data,
  output logic                              busy,
  output logic [3:0]                        thrd_cmd,
  output logic [DATA_SIZE-1:0]              tm_data,
  output logic [ADDR_SIZE-1:0]              tm_addr,
  input  logic [1:0]                        tm_rslt,
  input  logic [DATA_SIZE-1:0]              tm_data_in
);

  localparam logic [3:0] THREAD_CMD_RUN            = 4'h1;
  localparam logic [3:0] THREAD_CMD_STOP           = 4'h2;
  localparam logic [3:0] THREAD_CMD_GET_NEXT_STATE = 4'h3;
  localparam int         IDX_W                     = $clog2(CPU_QUANTITY);

  if (CPU_QUANTITY < 2 || CPU_QUANTITY > 8) begin : g_bad_cpu_qty
    $error("thrd_cmd_arbiter: CPU_QUANTITY must be 2..8");
  end
  if (QUANTUM < 8) begin : g_bad_quantum
    $error("thrd_cmd_arbiter: QUANTUM must be at least 8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
`ifdef THRD_ARB_QUANTUM_EN
    , S_TICK
`endif
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        last_q;
  logic [CPU_QUANTITY-1:0] done_q;
  logic [1:0]              rslt_q;
  logic [DATA_SIZE-1:0]    rdata_q;
  logic [3:0]              cmd_q;
  logic [DATA_SIZE-1:0]    tmd_q;
  logic [ADDR_SIZE-1:0]    tma_q;

  logic [3:0]              cmd_a  [CPU_QUANTITY];
  logic [DATA_SIZE-1:0]    data_a [CPU_QUANTITY];
  logic [ADDR_SIZE-1:0]    addr_a [CPU_QUANTITY];

  logic                    win_vld;
  logic [IDX_W-1:0]        win_idx;
  logic [IDX_W-1:0]        cand;

  function automatic logic legal_cmd(input logic [3:0] c);
    return (c == THREAD_CMD_RUN) || (c == THREAD_CMD_STOP);
  endfunction

  for (genvar g = 0; g < CPU_QUANTITY; g++) begin : g_unpack
    assign cmd_a[g]  = cmd_in[4*g +: 4];
    assign data_a[g] = data_in[DATA_SIZE*g +: DATA_SIZE];
    assign addr_a[g] = addr_in[ADDR_SIZE*g +: ADDR_SIZE];
  end

  // Scan downwards so the candidate nearest to last+1 is the one left standing.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = CPU_QUANTITY; i >= 1; i--) begin
      cand = IDX_W'((int'(last_q) + i) % CPU_QUANTITY);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef THRD_ARB_QUANTUM_EN
  localparam int CNT_W = $clog2(QUANTUM);
  logic [CNT_W-1:0] qcnt_q;
  logic             pend_q;

  // Free-running quantum; a fresh expiry wins over the clear from an issued tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt_q <= '0;
      pend_q <= 1'b0;
    end else if (qcnt_q == CNT_W'(QUANTUM - 1)) begin
      qcnt_q <= '0;
      pend_q <= 1'b1;
    end else begin
      qcnt_q <= qcnt_q + CNT_W'(1);
      if (state_q == S_IDLE && pend_q) pend_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IDX_W'(CPU_QUANTITY - 1);
      done_q  <= '0;
      rslt_q  <= '0;
      rdata_q <= '0;
      cmd_q   <= '0;
      tmd_q   <= '0;
      tma_q   <= '0;
    end else begin
      done_q <= '0;
      cmd_q  <= '0;
      case (state_q)
        S_IDLE: begin
`ifdef THRD_ARB_QUANTUM_EN
          if (pend_q) begin
            cmd_q   <= THREAD_CMD_GET_NEXT_STATE;
            state_q <= S_TICK;
          end else
`endif
          if (win_vld) begin
            last_q <= win_idx;
            if (legal_cmd(cmd_a[win_idx])) begin
              cmd_q   <= cmd_a[win_idx];
              tmd_q   <= data_a[win_idx];
              tma_q   <= addr_a[win_idx];
              state_q <= S_ISSUE;
            end else begin
              // Illegal command never reaches the manager; answer with zero result.
              rslt_q  <= '0;
              rdata_q <= '0;
              done_q  <= CPU_QUANTITY'(1) << win_idx;
              state_q <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          tmd_q   <= '0;
          tma_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          rslt_q  <= tm_rslt;
          rdata_q <= tm_data_in;
          done_q  <= CPU_QUANTITY'(1) << last_q;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
`ifdef THRD_ARB_QUANTUM_EN
        S_TICK:  state_q <= S_IDLE;
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign rslt      = rslt_q;
  assign rslt_data = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign thrd_cmd  = cmd_q;
  assign tm_data   = tmd_q;
  assign tm_addr   = tma_q;

endmodule

// File: tb/tb_thrd_cmd_arbiter.sv
// Bench for thrd_cmd_arbiter: directed literal checks plus randomized traffic against a schedule-based model.
module tb_thrd_cmd_arbiter;
  localparam int N  = 4;
`ifdef THRD_ARB_QUANTUM_EN
  localparam int Q   = 8;
  localparam bit QEN = 1'b1;
`else
  localparam int Q   = 64;
  localparam bit QEN = 1'b0;
`endif
  localparam int DS = 32;
  localparam int AS = 32;
  localparam logic [3:0] C_RUN  = 4'h1;
  localparam logic [3:0] C_STOP = 4'h2;
  localparam logic [3:0] C_GNS  = 4'h3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [4*N-1:0]  cmd_in = '0;
  logic [DS*N-1:0] data_in = '0;
  logic [AS*N-1:0] addr_in = '0;
  logic [1:0]      tm_rslt = '0;
  logic [DS-1:0]   tm_data_in = '0;
  logic [N-1:0]    done;
  logic [1:0]      rslt;
  logic [DS-1:0]   rslt_data;
  logic            busy;
  logic [3:0]      thrd_cmd;
  logic [DS-1:0]   tm_data;
  logic [AS-1:0]   tm_addr;

  thrd_cmd_arbiter #(.CPU_QUANTITY(N), .QUANTUM(Q), .DATA_SIZE(DS), .ADDR_SIZE(AS)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd_in(cmd_in), .data_in(data_in), .addr_in(addr_in),
    .done(done), .rslt(rslt), .rslt_data(rslt_data), .busy(busy), .thrd_cmd(thrd_cmd),
    .tm_data(tm_data), .tm_addr(tm_addr), .tm_rslt(tm_rslt), .tm_data_in(tm_data_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each grant schedules the cycle numbers of its issue, capture and done events.
  int            cyc = 0;
  bit            m_ok = 1'b0;
  int            free_c, issue_c, cap_c, done_c, tick_c, ecount, last, w;
  bit            pend;
  logic [3:0]    m_icmd, wcmd;
  logic [DS-1:0] m_idata, m_rdata;
  logic [AS-1:0] m_iaddr;
  logic [N-1:0]  m_dmask;
  logic [1:0]    m_rslt;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1;
      free_c = 0; issue_c = -10; cap_c = -10; done_c = -10; tick_c = -10;
      ecount = 0; last = N - 1; pend = 1'b0;
      m_rslt = '0; m_rdata = '0; m_dmask = '0;
    end else if (m_ok) begin
      if (cyc == cap_c) begin
        m_rslt  = tm_rslt;
        m_rdata = tm_data_in;
      end
      ecount++;
      if (cyc >= free_c) begin
        if (QEN && pend) begin
          tick_c = cyc + 1; free_c = cyc + 2; pend = 1'b0;
        end else if (req != '0) begin
          w = -1;
          for (int i = 1; i <= N; i++)
            if (w < 0 && req[(last + i) % N]) w = (last + i) % N;
          last = w;
          m_dmask = '0;
          m_dmask[w] = 1'b1;
          wcmd = cmd_in[4*w +: 4];
          if (wcmd == C_RUN || wcmd == C_STOP) begin
            issue_c = cyc + 1; cap_c = cyc + 2; done_c = cyc + 3; free_c = cyc + 4;
            m_icmd  = wcmd;
            m_idata = data_in[DS*w +: DS];
            m_iaddr = addr_in[AS*w +: AS];
          end else begin
            done_c = cyc + 1; free_c = cyc + 2;
            m_rslt = '0; m_rdata = '0;
          end
        end
      end
      if (QEN && (ecount % Q == 0)) pend = 1'b1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("done", done, (cyc == done_c) ? m_dmask : '0);
      chk("busy", busy, cyc < free_c);
      chk("thrd_cmd", thrd_cmd, (cyc == issue_c) ? m_icmd : ((cyc == tick_c) ? C_GNS : 4'h0));
      chk("rslt", rslt, m_rslt);
      chk("rslt_data", rslt_data, m_rdata);
      if (cyc == issue_c) begin
        chk("tm_data", tm_data, m_idata);
        chk("tm_addr", tm_addr, m_iaddr);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] rc;

  initial begin
    step(2);
    rst = 1'b0;
    chk("rst_done", done, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd", thrd_cmd, 4'h0);
    chk("rst_rslt", rslt, 2'd0);
    chk("rst_rdata", rslt_data, '0);
    chk("rst_tm_data", tm_data, '0);
    chk("rst_tm_addr", tm_addr, '0);

    // CPU0 RUN with manager returning 1 / all ones
    req = 4'b0001; cmd_in[3:0] = C_RUN; data_in[31:0] = 32'h55; addr_in[31:0] = 32'h100;
    tm_rslt = 2'd1; tm_data_in = 32'hFFFF_FFFF;
    step(1);
    chk("t1_cmd", thrd_cmd, C_RUN);
    chk("t1_tm_data", tm_data, 32'h55);
    chk("t1_tm_addr", tm_addr, 32'h100);
    chk("t1_busy", busy, 1'b1);
    step(1);
    chk("t2_cmd", thrd_cmd, 4'h0);
    step(1);
    chk("t3_done", done, 4'b0001);
    chk("t3_rslt", rslt, 2'd1);
    chk("t3_rdata", rslt_data, 32'hFFFF_FFFF);
    req = '0;
    step(1);
    chk("t4_busy", busy, 1'b0);

    // CPU2 illegal command
    req = 4'b0100; cmd_in[11:8] = 4'hF;
    step(1);
    chk("ill_done", done, 4'b0100);
    chk("ill_cmd", thrd_cmd, 4'h0);
    chk("ill_rslt", rslt, 2'd0);
    chk("ill_rdata", rslt_data, '0);
    req = '0;
    step(1);

    // CPU1 drops req during WAIT, then reset during WAIT
    rst = 1'b1; step(1); rst = 1'b0;
    req = 4'b0010; cmd_in[7:4] = C_STOP;
    step(1);
    chk("drop_cmd", thrd_cmd, C_STOP);
    step(1);
    req = '0;
    step(1);
    chk("drop_done", done, 4'b0010);
    step(1);
    req = 4'b0010;
    step(2);
    rst = 1'b1;
    step(1);
    chk("rstw_done", done, '0);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_cmd", thrd_cmd, 4'h0);
    rst = 1'b0; req = '0;
    step(1);

`ifndef THRD_ARB_QUANTUM_EN
    // All four CPUs continuously
    rst = 1'b1; step(1); rst = 1'b0;
    req = 4'b1111; cmd_in = {C_RUN, C_RUN, C_RUN, C_RUN};
    step(3);
    chk("rr0", done, 4'b0001);
    step(4);
    chk("rr1", done, 4'b0010);
    step(4);
    chk("rr2", done, 4'b0100);
    step(4);
    chk("rr3", done, 4'b1000);
    step(4);
    chk("rr4", done, 4'b0001);
    req = '0;
    step(2);
    for (int i = 0; i < 1000; i++) begin
      step(1);
      chk("idle_cmd", thrd_cmd, 4'h0);
    end
`else
    // Ticks with QUANTUM=8 and expiry inside a transaction
    rst = 1'b1; step(1); rst = 1'b0;
    step(9);
    chk("tick1", thrd_cmd, C_GNS);
    chk("tick1_busy", busy, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("tick_gap", thrd_cmd, 4'h0);
    end
    step(1);
    chk("tick2", thrd_cmd, C_GNS);
    step(5);
    req = 4'b0001; cmd_in[3:0] = C_RUN;
    step(3);
    chk("qt_done", done, 4'b0001);
    step(2);
    chk("qt_tick", thrd_cmd, C_GNS);
    chk("qt_tick_done", done, '0);
    step(2);
    chk("qt_regrant", thrd_cmd, C_RUN);
    req = '0;
    step(4);
`endif

    // Randomized traffic
    rst = 1'b1; step(1); rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < N; c++) begin
        if (done[c]) begin
          if ($urandom_range(3) != 0) req[c] = 1'b0;
        end else if (!req[c]) begin
          if ($urandom_range(3) == 0) begin
            req[c] = 1'b1;
            case ($urandom_range(9))
              0, 1, 2, 3: rc = C_RUN;
              4, 5, 6, 7: rc = C_STOP;
              default:    rc = 4'($urandom);
            endcase
            cmd_in[4*c +: 4]   = rc;
            data_in[DS*c +: DS] = $urandom;
            addr_in[AS*c +: AS] = $urandom;
          end
        end else if ($urandom_range(40) == 0) begin
          req[c] = 1'b0;
        end
      end
      tm_rslt    = 2'($urandom);
      tm_data_in = $urandom;
      rst        = ($urandom_range(299) == 0);
      step(1);
    end
    rst = 1'b0; req = '0;
    step(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/thrd_cmd_arbiter.md
# thrd_cmd_arbiter

Round-robin arbiter that shares the single thread-command port of the threads manager among `CPU_QUANTITY` CPU requesters. It serialises RUN/STOP requests into one-cycle command pulses with operand data/address, returns the manager's result to the winning CPU, and optionally injects periodic GET_NEXT_STATE ticks as the scheduling quantum. It sits between the CPU cluster and the threads manager, on the controller clock.

## Interface
- `CPU_QUANTITY`, 4, number of requesting CPUs (2..8)
- `QUANTUM`, 64, quantum length in clk cycles (minimum 8)
- `clk`  in  1  controller clock
- `rst`  in  1  synchronous, active-high reset
- `req`  in  CPU_QUANTITY  per-CPU request; held high until that CPU's `done` bit pulses
- `cmd_in`  in  4*CPU_QUANTITY  packed thread command per CPU (CPU k at bits 4k+3:4k)
- `data_in`  in  `DATA_SIZE`*CPU_QUANTITY  packed operand data (thread argument)
- `addr_in`  in  `ADDR_SIZE`*CPU_QUANTITY  packed operand address (thread entry / id)
- `done`  out  CPU_QUANTITY  one-hot, one-cycle completion pulse to the served CPU
- `rslt`  out  2  result of last completed request
- `rslt_data`  out  `DATA_SIZE`  data returned with last completed request
- `busy`  out  1  high in every state except IDLE
- `thrd_cmd`  out  4  command to threads manager; 4'h0 when idle
- `tm_data`  out  `DATA_SIZE`  operand data to threads manager
- `tm_addr`  out  `ADDR_SIZE`  operand address to threads manager
- `tm_rslt`  in  2  threads manager result
- `tm_data_in`  in  `DATA_SIZE`  threads manager returned data

## Operation
- States: IDLE, ISSUE, WAIT, DONE, TICK (TICK only with quantum feature).
- IDLE: if quantum pending -> TICK (takes priority over requests). Else if any `req` -> select winner, latch its cmd/data/addr, -> ISSUE (or -> DONE directly for illegal command). Else stay.
- Winner: first asserted `req` searching from `last+1` modulo CPU_QUANTITY; `last` updated to winner on entry to ISSUE/DONE.
- Legal commands: `THREAD_CMD_RUN`, `THREAD_CMD_STOP`. Any other `cmd_in` value -> no manager access; DONE with `rslt`=0, `rslt_data`=0.
- ISSUE: `thrd_cmd`, `tm_data`, `tm_addr` driven with latched values for exactly one cycle -> WAIT.
- WAIT: `thrd_cmd`=0; `tm_rslt`, `tm_data_in` captured at end of cycle -> DONE.
- DONE: `done[winner]`=1 for one cycle; `rslt`/`rslt_data` updated on DONE entry and held until next DONE -> IDLE.
- TICK: `thrd_cmd`=`THREAD_CMD_GET_NEXT_STATE` one cycle, pending cleared, no `done` pulse -> IDLE.
- `req` dropped mid-transaction: transaction still completes and `done` still pulses; no abort.
- `req` of the winner still high after `done`: treated as a new request.

## Timing
- Reset values: `done`=0, `rslt`=0, `rslt_data`=0, `busy`=0, `thrd_cmd`=0, `tm_data`=0, `tm_addr`=0, state IDLE, `last`=CPU_QUANTITY-1 (CPU0 wins first), quantum counter 0, pending 0.
- Request seen in IDLE at edge t -> ISSUE cycle t+1 -> WAIT t+2 -> `done` high t+3 -> IDLE t+4. Illegal command: `done` at t+1.
- Max throughput: one manager command per 4 cycles.
- Quantum counter free-runs in all states; reaching QUANTUM-1 sets pending and wraps to 0. Expiry while pending already set is absorbed (no double tick).
- Reset mid-transaction: return to IDLE next cycle, no `done` pulse, `thrd_cmd`=0 immediately after the reset edge.

## Configuration
- `THRD_ARB_QUANTUM_EN` defined: quantum counter, pending flag and TICK state present; GET_NEXT_STATE emitted every QUANTUM cycles.
- Not defined: no counter, no TICK; `thrd_cmd` only ever 0, RUN or STOP; `QUANTUM` ignored.

## Test plan
- Reset, CPU0 requests RUN, data=32'h55, addr=32'h100, tm_rslt=1, tm_data_in=-1 -> thrd_cmd=RUN one cycle at t+1, done=4'b0001 at t+3, rslt=1, rslt_data=32'hFFFF_FFFF.
- All four CPUs request continuously -> done order 0,1,2,3,0, pulses 4 cycles apart.
- CPU2 issues cmd 4'hF -> thrd_cmd stays 0, done=4'b0100 at t+1, rslt=0, rslt_data=0.
- With `THRD_ARB_QUANTUM_EN`, QUANTUM=8, no requests -> GET_NEXT_STATE pulse every 8 cycles; expiry during transaction -> TICK immediately after DONE/IDLE, before next grant.
- CPU1 drops req during WAIT -> done=4'b0010 still pulses; rst asserted in WAIT -> no done, busy=0 next cycle.
- Without `THRD_ARB_QUANTUM_EN`, 1000 idle cycles -> thrd_cmd never non-zero.
